// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, ALU operation and the request-unit state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB,
    ALU_AND, ALU_OR,  ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DATA   = 2'd2,
    HALTED = 2'd3
  } reqstate_t;

endpackage

// File: rtl/request_unit_if.sv
// Bundle of request_unit signals with block-side, bench-side and control-unit views.
interface request_unit_if #(parameter int CNT_W = 32);

  logic             dREN, dWEN, halt;
  logic             ihit, dhit;
  logic             imemREN, dmemREN, dmemWEN;
  logic             pc_en, halted;
  logic [CNT_W-1:0] instr_cnt, stall_cnt;

  modport ru (
    input  dREN, dWEN, halt, ihit, dhit,
    output imemREN, dmemREN, dmemWEN, pc_en, halted, instr_cnt, stall_cnt
  );

  modport tb (
    output dREN, dWEN, halt, ihit, dhit,
    input  imemREN, dmemREN, dmemWEN, pc_en, halted, instr_cnt, stall_cnt
  );

  // The control unit produces the decodes and sees the PC-advance strobe.
  modport cu (
    output dREN, dWEN, halt,
    input  pc_en
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/request_unit.sv
// Memory-request sequencer for the single-port CPU (fetch / data / halt).
// Statistics counters are built only when REQUEST_UNIT_STATS_EN is defined.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic             halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  reqstate_t state_q, state_d;
  logic      dmemREN_q, dmemREN_d;
  logic      dmemWEN_q, dmemWEN_d;
  logic      halted_q, halted_d;

  always_comb begin
    state_d   = state_q;
    dmemREN_d = dmemREN_q;
    dmemWEN_d = dmemWEN_q;
    halted_d  = halted_q;
    imemREN   = 1'b0;
    pc_en     = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          if (halt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else if (dREN || dWEN) begin
            // A simultaneous read and write resolves to the write.
            state_d   = DATA;
            dmemREN_d = dREN & ~dWEN;
            dmemWEN_d = dWEN;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          pc_en     = 1'b1;
          dmemREN_d = 1'b0;
          dmemWEN_d = 1'b0;
          state_d   = FETCH;
        end
      end
      HALTED: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dmemREN_q <= 1'b0;
      dmemWEN_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dmemREN_q <= dmemREN_d;
      dmemWEN_q <= dmemWEN_d;
      halted_q  <= halted_d;
    end
  end

  assign dmemREN = dmemREN_q;
  assign dmemWEN = dmemWEN_q;
  assign halted  = halted_q;

`ifdef REQUEST_UNIT_STATS_EN
  logic stall_inc;
  assign stall_inc = ((state_q == FETCH) && !ihit) || ((state_q == DATA) && !dhit);

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .CLK (CLK),
    .nRST(nRST),
    .en  (pc_en),
    .cnt (instr_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .nRST(nRST),
    .en  (stall_inc),
    .cnt (stall_cnt)
  );
`else
  assign instr_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed scenarios plus randomized traffic
// compared against a flag-based behavioural model of the sequencer.
module tb_request_unit;

  localparam int CNT_W = 4;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
`ifdef REQUEST_UNIT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             CLK, nRST;
  logic             dREN, dWEN, halt, ihit, dhit;
  logic             imemREN, dmemREN, dmemWEN, pc_en, halted;
  logic [CNT_W-1:0] instr_cnt, stall_cnt;

  request_unit #(.CNT_W(CNT_W)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .halt     (halt),
    .ihit     (ihit),
    .dhit     (dhit),
    .imemREN  (imemREN),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .pc_en    (pc_en),
    .halted   (halted),
    .instr_cnt(instr_cnt),
    .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the block is "running" once reset has been released for an
  // edge; an outstanding data request (rd/wr) means a data access is in flight.
  bit     m_running, m_halted, m_rd, m_wr;
  longint m_instr, m_stall;

  function automatic longint sat_inc(input longint v);
    return (v == CNT_MAX) ? v : v + 1;
  endfunction

  function automatic void model_reset();
    m_running = 0; m_halted = 0; m_rd = 0; m_wr = 0;
    m_instr = 0;   m_stall = 0;
  endfunction

  function automatic bit exp_pc_en();
    if (!m_running || m_halted) return 1'b0;
    if (m_rd || m_wr) return dhit;
    return ihit && !halt && !dREN && !dWEN;
  endfunction

  function automatic void model_edge();
    if (!m_running) begin
      m_running = 1;
    end else if (m_halted) begin
      // frozen until reset
    end else if (m_rd || m_wr) begin
      if (dhit) begin
        m_instr = sat_inc(m_instr);
        m_rd = 0; m_wr = 0;
      end else begin
        m_stall = sat_inc(m_stall);
      end
    end else if (ihit) begin
      if (halt)              m_halted = 1;
      else if (dREN || dWEN) begin m_wr = dWEN; m_rd = ~dWEN; end
      else                   m_instr = sat_inc(m_instr);
    end else begin
      m_stall = sat_inc(m_stall);
    end
  endfunction

  task automatic check_outputs(input string ph);
    chk({ph, ":imemREN"},   imemREN,   (m_running && !m_halted && !m_rd && !m_wr));
    chk({ph, ":dmemREN"},   dmemREN,   m_rd);
    chk({ph, ":dmemWEN"},   dmemWEN,   m_wr);
    chk({ph, ":pc_en"},     pc_en,     exp_pc_en());
    chk({ph, ":halted"},    halted,    m_halted);
    chk({ph, ":instr_cnt"}, instr_cnt, STATS ? m_instr : 0);
    chk({ph, ":stall_cnt"}, stall_cnt, STATS ? m_stall : 0);
  endtask

  // One clock cycle: drive, check mid-cycle, advance model on the edge.
  task automatic cycle(input string ph, input bit ih, input bit dh,
                       input bit rn, input bit wn, input bit hl);
    ihit = ih; dhit = dh; dREN = rn; dWEN = wn; halt = hl;
    @(negedge CLK);
    check_outputs(ph);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic rand_cycles(input string ph, input int n, input int halt_pct);
    for (int i = 0; i < n; i++)
      cycle(ph, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
            $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
            $urandom_range(99, 0) < halt_pct);
  endtask

  initial begin
    nRST = 0; ihit = 0; dhit = 0; dREN = 0; dWEN = 0; halt = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_outputs("reset");
    nRST = 1;

    // Reset release and first fetch with no hits.
    cycle("idle", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("first_fetch", 0, 0, 0, 0, 0);
    chk("stall_after_3", stall_cnt, STATS ? 3 : 0);

    // Back-to-back non-memory instructions.
    for (int i = 0; i < 4; i++) cycle("nonmem", 1, 0, 0, 0, 0);
    chk("instr_after_4", instr_cnt, STATS ? 4 : 0);

    // Load with dhit on the third data cycle.
    cycle("load_ihit", 1, 0, 1, 0, 0);
    cycle("load_wait", 1, 0, 0, 0, 0);
    cycle("load_wait", 0, 0, 0, 0, 0);
    chk("load_dmemREN_held", dmemREN, 1);
    cycle("load_dhit", 0, 1, 0, 0, 0);
    cycle("load_back", 0, 0, 0, 0, 0);

    // Illegal read+write: write wins.
    cycle("rdwr_ihit", 1, 0, 1, 1, 0);
    chk("rdwr_dmemWEN", dmemWEN, 1);
    chk("rdwr_dmemREN", dmemREN, 0);
    cycle("rdwr_dhit", 0, 1, 0, 0, 0);

    // Random traffic without halts; long enough to saturate small counters.
    rand_cycles("rand", 250, 0);

    // Reset during a data write: outputs clear without any clock edge.
    while (m_rd || m_wr || !m_running) cycle("drain", 0, 1, 0, 0, 0);
    cycle("rst_wr_ihit", 1, 0, 0, 1, 0);
    ihit = 0; dhit = 0; dREN = 0; dWEN = 0;
    @(negedge CLK);
    chk("rst_wr_pre", dmemWEN, 1);
    #2 nRST = 0;
    #1;
    model_reset();
    chk("rst_async_dmemWEN", dmemWEN, 0);
    check_outputs("rst_async");
    @(posedge CLK);
    #1 nRST = 1;
    cycle("rst_idle", 1, 1, 0, 0, 0);

    // Halt together with a write decode: halt wins, later hits ignored.
    while (m_rd || m_wr) cycle("drain2", 0, 1, 0, 0, 0);
    cycle("halt_ihit", 1, 0, 0, 1, 1);
    chk("halt_halted", halted, 1);
    chk("halt_no_wr", dmemWEN, 0);
    rand_cycles("post_halt", 10, 30);

    // Reset pulse leaves the halted state.
    @(negedge CLK);
    #1 nRST = 0;
    #1;
    model_reset();
    chk("unhalt_halted", halted, 0);
    @(posedge CLK);
    #1 nRST = 1;
    cycle("unhalt_idle", 1, 0, 0, 0, 0);

    // Random traffic with occasional halts.
    rand_cycles("rand_halt", 120, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/request_unit.md
# request_unit

Memory-request sequencer between the control unit and the instruction/data memory ports of the single-port CPU. It consumes the control unit's `dREN`, `dWEN` and `halt` decodes, issues instruction fetches and data accesses, and waits on the `ihit` and `dhit` handshakes. It produces the PC-advance strobe and a sticky halted flag. It sits beside the control unit in the datapath top level and is the only block that drives memory request lines.

## Interface

Parameters:
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `dREN`  in  1  control unit decode: the current instruction reads memory.
- `dWEN`  in  1  control unit decode: the current instruction writes memory.
- `halt`  in  1  control unit decode: the current instruction is a halt.
- `ihit`  in  1  instruction memory has returned the instruction word.
- `dhit`  in  1  data memory has completed the access.
- `imemREN`  out  1  instruction fetch request.
- `dmemREN`  out  1  data read request, registered.
- `dmemWEN`  out  1  data write request, registered.
- `pc_en`  out  1  single-cycle PC advance strobe.
- `halted`  out  1  sticky halt flag, registered.
- `instr_cnt`  out  CNT_W  number of retired instructions.
- `stall_cnt`  out  CNT_W  number of cycles spent waiting on a hit.

## Operation

The block is a state machine with four states: IDLE, FETCH, DATA and HALTED.

- **IDLE** (reset state):
  - All outputs are 0.
  - Always moves to FETCH on the next edge.
- **FETCH**:
  - `imemREN`=1.
  - `dREN`, `dWEN` and `halt` are sampled only when `ihit`=1.
  - `ihit`=1 with `halt`=1: go to HALTED. `pc_en` stays 0, so the PC stays on the halt instruction.
  - `ihit`=1 with `dREN` or `dWEN` set: go to DATA. Register `dmemREN` = `dREN` & ~`dWEN` and `dmemWEN` = `dWEN`.
    - If both are set, the write wins. This combination is illegal, but the behaviour is defined.
  - `ihit`=1 with none of the three set: `pc_en`=1 combinationally that cycle, and the state stays FETCH.
  - `halt` takes priority over `dREN`/`dWEN` in the same cycle.
  - `dhit` is ignored in FETCH.
- **DATA**:
  - `imemREN`=0, because the memory port is single and shared.
  - `dmemREN`/`dmemWEN` are held stable until `dhit`.
  - On `dhit`=1: `pc_en`=1 combinationally, both request registers clear on the edge, and the state returns to FETCH.
  - `ihit` is ignored in DATA.
- **HALTED**:
  - `halted`=1; every other output is 0.
  - The state is left only through reset.
- **Counters** (statistics build only):
  - `instr_cnt` increments on each cycle with `pc_en`=1.
  - `stall_cnt` increments on each cycle in FETCH without `ihit`, and on each cycle in DATA without `dhit`.
  - Both counters saturate at all-ones and reset to 0.

## Timing

- **Reset values**:
  - `imemREN`, `dmemREN`, `dmemWEN`, `pc_en`, `halted` = 0.
  - Counters = 0.
  - State = IDLE.
- **Reset assertion mid-operation**: all registered outputs clear immediately (asynchronous reset), and the state returns to IDLE. Outstanding requests are dropped without waiting for a hit.
- **First fetch**: `imemREN` rises one edge after `nRST` deasserts.
- **Non-memory instruction**: `pc_en` is high in the `ihit` cycle, so the minimum is 1 cycle per instruction.
- **Load/store**:
  - `dmemREN`/`dmemWEN` are high starting the cycle after `ihit`.
  - `pc_en` is high in the `dhit` cycle.
  - Minimum is 2 cycles per instruction.
- **`halted`**: rises on the edge that ends the `ihit` cycle of the halt instruction.
- **Hit handling**: hits may stay high for many cycles. Each edge in FETCH with `ihit` high is treated as a new instruction. `ihit` arriving in the same cycle as a transition into DATA has no effect.

## Configuration

- `REQUEST_UNIT_STATS_EN` defined: both counters are implemented and drive `instr_cnt`/`stall_cnt`.
- `REQUEST_UNIT_STATS_EN` undefined:
  - No counter logic is built.
  - `instr_cnt` and `stall_cnt` are tied to 0.
  - The port list is unchanged.

## Structure

- The state enum `reqstate_t` (IDLE, FETCH, DATA, HALTED; 2 bits) belongs in `cpu_types_pkg`, next to `word_t` and `aluop_t`.
- Sub-module `sat_counter` (width-parameterised, with enable, saturating at all-ones) is instantiated twice under the macro.
- A companion interface `request_unit_if` carries the following modports:
  - `ru`: the block's own side.
  - `tb`: the testbench side.
  - `cu`: shares `dREN`/`dWEN`/`halt` with the control unit interface.

## Test plan

- **Reset and first fetch**: release `nRST`, then hold `ihit`=0 for 3 cycles. Required: `imemREN`=1 from cycle 1, `stall_cnt`=3, `pc_en`=0 throughout.
- **Non-memory instructions**: assert `ihit` for 1 cycle with all decodes 0, repeated 4 times back-to-back. Required: 4 `pc_en` pulses, `instr_cnt`=4.
- **Load**: `ihit` with `dREN`=1, then `dhit` after 2 cycles. Required:
  - `dmemREN`=1 for 3 cycles and `imemREN`=0 during them.
  - `pc_en` high only in the `dhit` cycle.
  - Back in FETCH on the next edge.
- **Illegal read+write**: `ihit` with `dREN`=`dWEN`=1. Required: `dmemWEN`=1, `dmemREN`=0.
- **Halt**: `ihit` with `halt`=1 and `dWEN`=1 together. Required:
  - `halted`=1 on the next edge, with no data request and no `pc_en`.
  - Later hits are ignored.
  - `nRST` pulse returns the block to IDLE with `halted`=0.
- **Reset during DATA**: assert `nRST`=0 while `dmemWEN`=1. Required: `dmemWEN`=0 within the same cycle, with no dependence on the clock, and counters cleared.
